// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizing for the register-file writeback controller.
package rf_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;

    // A register may have at most this many writes in flight.
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Round-robin pointer: which requester wins when both are valid.
    typedef enum logic {
        PRIO_LD = 1'b0,
        PRIO_EX = 1'b1
    } prio_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue throttling, RAW busy lookups
// and a sticky error flag for writes nobody was waiting for.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              commit_valid,
    input  logic [REG_AW-1:0] commit_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              sb_err
);

    // Entry 0 is held at reset value forever, so x0 is never busy.
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            inc_vec;
    logic [NREG-1:0]            dec_vec;
    logic                       issue_fire;

    // Issue stalls only when its destination counter is saturated.
    always_comb begin
        issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);
        issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
    end

    // Hazard lookups are purely combinational on the live counters.
    always_comb begin
        rs1_busy = (cnt[rs1_addr] != '0);
        rs2_busy = (cnt[rs2_addr] != '0);
    end

    // One-hot decode of the increment and decrement targets.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec[i] = issue_fire   && (issue_rd  == REG_AW'(i));
            dec_vec[i] = commit_valid && (commit_rd == REG_AW'(i));
        end
    end

    // Counter update; a simultaneous issue and commit to one register cancel.
    // A decrement at zero is absorbed (counter stays 0) and flagged below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // Sticky: a write landed on a register with no outstanding issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (commit_valid && (commit_rd != '0) && (cnt[commit_rd] == '0))
            sb_err <= 1'b1;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: round-robin arbitration between execute and load
// writebacks, a one-entry registered write stage feeding the register file,
// and the pending-write scoreboard.
module rf_wb_ctrl
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    output logic              issue_ready,

    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    output logic              ex_ready,

    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,

    output logic              reg_we,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_wdata,

    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              sb_err
);

    prio_e   prio;
    wb_req_t ex_req;
    wb_req_t ld_req;
    wb_req_t win_req;
    logic    xfer;
    logic    wr_fire;

    assign ex_req = '{rd: ex_rd, data: ex_data};
    assign ld_req = '{rd: ld_rd, data: ld_data};

    // Grants depend only on the valids and the pointer; the write stage
    // always accepts, so there is no downstream term.
    always_comb begin
        ex_ready = ex_valid && (!ld_valid || (prio == PRIO_EX));
        ld_ready = ld_valid && (!ex_valid || (prio == PRIO_LD));
        xfer     = ex_ready || ld_ready;
        win_req  = ex_ready ? ex_req : ld_req;
        // Writes to x0 are consumed but never reach the register file.
        wr_fire  = xfer && (win_req.rd != '0);
    end

    // Pointer flips to the other requester after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= PRIO_LD;
        else if (ex_ready)
            prio <= PRIO_LD;
        else if (ld_ready)
            prio <= PRIO_EX;
    end

    // Registered write stage; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we   <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else begin
            reg_we <= wr_fire;
            if (wr_fire) begin
                rd_addr  <= win_req.rd;
                rd_wdata <= win_req.data;
            end
        end
    end

    // The write stage output doubles as the scoreboard commit, so busy
    // clears at the same edge the register file takes the data.
    rf_scoreboard u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .commit_valid (reg_we),
        .commit_rd    (rd_addr),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .sb_err       (sb_err)
    );

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed scenarios and random traffic, all checked
// against a transaction-level model of grants, writes and pending counts.
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_data = '0;
    logic        ex_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        reg_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        sb_err;

    always #5 clk = ~clk;

    rf_wb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ex_ready    (ex_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .reg_we      (reg_we),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .sb_err      (sb_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: outstanding writes per register, the pointer as
    // "who wins a tie next", the pending register-file write, sticky error.
    int          m_cnt [32];
    bit          m_ex_next;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_err;
    bit          g_ex, g_ld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_ex_next = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_err     = 1'b0;
        g_ex      = 1'b0;
        g_ld      = 1'b0;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    endtask

    task automatic check_regs();
        chk("reg_we",   {31'd0, reg_we}, {31'd0, m_we});
        chk("rd_addr",  {27'd0, rd_addr}, {27'd0, m_addr});
        chk("rd_wdata", rd_wdata, m_data);
        chk("sb_err",   {31'd0, sb_err}, {31'd0, m_err});
    endtask

    // One clock: check combinational outputs for the current inputs, then
    // advance the model across the edge and check registered outputs.
    task automatic step();
        bit         gex, gld, inc, dec;
        logic [4:0] wrd;
        logic [31:0] wdat;
        #1;
        if (ex_valid && ld_valid) begin
            gex = m_ex_next;
            gld = !m_ex_next;
        end else begin
            gex = ex_valid;
            gld = ld_valid;
        end
        chk("ex_ready", {31'd0, ex_ready}, {31'd0, gex});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, gld});
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, (issue_rd == 0) || (m_cnt[issue_rd] != 3)});
        chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, m_cnt[rs1_addr] != 0});
        chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, m_cnt[rs2_addr] != 0});
        wrd  = gex ? ex_rd : ld_rd;
        wdat = gex ? ex_data : ld_data;
        @(posedge clk);
        inc = issue_valid && (issue_rd != 0) && (m_cnt[issue_rd] != 3);
        dec = m_we;
        if (dec && m_cnt[m_addr] == 0) m_err = 1'b1;
        if (inc && !(dec && m_addr == issue_rd)) m_cnt[issue_rd]++;
        if (dec && !(inc && m_addr == issue_rd) && m_cnt[m_addr] != 0) m_cnt[m_addr]--;
        if (gex || gld) m_ex_next = gld;
        if ((gex || gld) && wrd != 0) begin
            m_we = 1'b1; m_addr = wrd; m_data = wdat;
        end else begin
            m_we = 1'b0;
        end
        g_ex = gex;
        g_ld = gld;
        #1;
        check_regs();
    endtask

    // Assert reset away from an edge; outputs must drop immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs();
        chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        do_reset();
        chk("reset_issue_ready", {31'd0, issue_ready}, 32'd1);

        // Single load writeback.
        ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
        step();
        chk("ld_only_wdata", rd_wdata, 32'hDEADBEEF);
        chk("ld_only_addr", {27'd0, rd_addr}, 32'd5);
        idle_inputs();
        step();

        // Both requesters held for four cycles: LD, EX, LD, EX.
        do_reset();
        ex_valid = 1'b1; ex_rd = 5'd2; ex_data = 32'h0000_E000;
        ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h0000_1000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_order_ld", {31'd0, g_ld}, {31'd0, (k % 2) == 0});
            chk("rr_we", {31'd0, reg_we}, 32'd1);
            if (g_ex) ex_data = ex_data + 1;
            if (g_ld) ld_data = ld_data + 1;
        end
        idle_inputs();
        step();

        // Saturate register 7, then drain it with load writebacks.
        do_reset();
        rs1_addr = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        repeat (3) step();
        chk("sat_busy", {31'd0, rs1_busy}, 32'd1);
        chk("sat_ready", {31'd0, issue_ready}, 32'd0);
        step();  // stalled issue must not count
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7;
        step();
        ld_valid = 1'b0;
        step();  // commit lands here
        issue_rd = 5'd7;
        #1;
        chk("drain1_ready", {31'd0, issue_ready}, 32'd1);
        chk("drain1_busy", {31'd0, rs1_busy}, 32'd1);
        ld_valid = 1'b1;
        step();
        step();
        ld_valid = 1'b0;
        step();
        chk("drain3_busy", {31'd0, rs1_busy}, 32'd0);

        // Issue and commit to the same register in one cycle.
        do_reset();
        rs2_addr = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        step();
        ld_valid = 1'b0;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        chk("same_cycle_busy", {31'd0, rs2_busy}, 32'd1);
        step();

        // x0 writeback is consumed silently; stray commit sets sticky error.
        do_reset();
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'h1234;
        step();
        chk("x0_we", {31'd0, reg_we}, 32'd0);
        ex_rd = 5'd3;
        step();
        ex_valid = 1'b0;
        step();
        chk("stray_err", {31'd0, sb_err}, 32'd1);
        repeat (2) step();
        chk("err_sticky", {31'd0, sb_err}, 32'd1);

        // Reset while a write is pending in the output stage.
        rs1_addr = 5'd4;
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h44;
        step();
        chk("pre_rst_we", {31'd0, reg_we}, 32'd1);
        do_reset();
        chk("post_rst_busy", {31'd0, rs1_busy}, 32'd0);
        ex_valid = 1'b1; ld_valid = 1'b1; ex_rd = 5'd1; ld_rd = 5'd2;
        step();
        chk("post_rst_prio", {31'd0, g_ld}, 32'd1);
        idle_inputs();
        step();

        // Random traffic over a handful of registers.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            if (!ex_valid || g_ex) begin
                ex_valid = ($urandom % 3) != 0;
                ex_rd    = 5'($urandom_range(0, 5));
                ex_data  = $urandom;
            end
            if (!ld_valid || g_ld) begin
                ld_valid = ($urandom % 3) != 0;
                ld_rd    = 5'($urandom_range(0, 5));
                ld_data  = $urandom;
            end
            g_ex = 1'b0;
            g_ld = 1'b0;
            issue_valid = ($urandom % 4) != 0;
            issue_rd    = 5'($urandom_range(0, 5));
            rs1_addr    = 5'($urandom_range(0, 6));
            rs2_addr    = 5'($urandom_range(0, 6));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
